// File: rtl/fetch_unit_pkg.sv
// Shared state encodings and default widths for the instruction fetch front-end.
// The include-guarded defines are usable by files that do not import the package.
`ifndef FETCH_UNIT_DEFS_SVH
`define FETCH_UNIT_DEFS_SVH
`define FS_IDLE 2'd0
`define FS_REQ  2'd1
`define FS_HOLD 2'd2
`define FETCH_AW 16
`define FETCH_DW 16
`endif

package fetch_unit_pkg;
   typedef enum logic [1:0] {
      IDLE = `FS_IDLE,
      REQ  = `FS_REQ,
      HOLD = `FS_HOLD
   } fetch_state_t;

   localparam int DEF_AW = `FETCH_AW;
   localparam int DEF_DW = `FETCH_DW;
endpackage

// File: rtl/fetch_unit_timer.sv
// Memory-wait counter for the fetch unit; used only when FETCH_TIMEOUT_EN is defined.
module fetch_timer
   import fetch_unit_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ack,
   output logic expired
);
   logic [7:0] cnt_reg;

   // Held at zero outside REQ, so every new request starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (!active || ack)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 8'd1;
   end

   // An ack in the final cycle wins over the timeout.
   assign expired = active && !ack && (cnt_reg == 8'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: one outstanding memory read, one-entry instruction buffer.
// Optional memory-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] pc_addr,
   output logic          pc_inc,
   input  logic          redirect,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          ir_valid,
   input  logic          ir_ready,
   output logic [DW-1:0] ir_data,
   output logic [AW-1:0] ir_pc,
   output logic          fetch_err
);
   fetch_state_t  state_reg, state_next;
   logic          kill_reg, kill_next;
   logic [AW-1:0] mem_addr_reg, mem_addr_next;
   logic [DW-1:0] ir_data_reg, ir_data_next;
   logic [AW-1:0] ir_pc_reg, ir_pc_next;
   logic          ir_valid_reg, ir_valid_next;
   logic          fetch_err_reg, fetch_err_next;
   logic          timeout;

`ifdef FETCH_TIMEOUT_EN
   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (state_reg == REQ),
      .ack     (mem_ack),
      .expired (timeout)
   );
`else
   logic unused_timeout_param;
   assign unused_timeout_param = (TIMEOUT == 0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         kill_reg      <= 1'b0;
         mem_addr_reg  <= '0;
         ir_data_reg   <= '0;
         ir_pc_reg     <= '0;
         ir_valid_reg  <= 1'b0;
         fetch_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         kill_reg      <= kill_next;
         mem_addr_reg  <= mem_addr_next;
         ir_data_reg   <= ir_data_next;
         ir_pc_reg     <= ir_pc_next;
         ir_valid_reg  <= ir_valid_next;
         fetch_err_reg <= fetch_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      kill_next      = kill_reg;
      mem_addr_next  = mem_addr_reg;
      ir_data_next   = ir_data_reg;
      ir_pc_next     = ir_pc_reg;
      ir_valid_next  = ir_valid_reg;
      fetch_err_next = fetch_err_reg;
      pc_inc         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!redirect) begin
               state_next    = REQ;
               mem_addr_next = pc_addr;
            end
         end
         REQ: begin
            if (mem_ack) begin
               kill_next = 1'b0;
               // A redirect arriving with the ack kills the word just like an earlier one.
               if (!kill_reg && !redirect) begin
                  ir_data_next  = mem_rdata;
                  ir_pc_next    = mem_addr_reg;
                  ir_valid_next = 1'b1;
                  pc_inc        = 1'b1;
                  state_next    = HOLD;
               end else begin
                  state_next = IDLE;
               end
            end else if (timeout) begin
               kill_next      = 1'b0;
               fetch_err_next = 1'b1;
               state_next     = IDLE;
            end else if (redirect) begin
               kill_next = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               ir_valid_next = 1'b0;
               state_next    = IDLE;
            end else if (ir_ready) begin
               ir_valid_next = 1'b0;
               mem_addr_next = pc_addr;
               state_next    = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_req   = (state_reg == REQ);
   assign mem_addr  = mem_addr_reg;
   assign ir_valid  = ir_valid_reg;
   assign ir_data   = ir_data_reg;
   assign ir_pc     = ir_pc_reg;
   assign fetch_err = fetch_err_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fetch_unit;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] pc_addr = '0;
   logic          pc_inc;
   logic          redirect = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          ir_valid;
   logic          ir_ready = 1'b0;
   logic [DW-1:0] ir_data;
   logic [AW-1:0] ir_pc;
   logic          fetch_err;

   always #5 clk = ~clk;

   fetch_unit #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_addr   (pc_addr),
      .pc_inc    (pc_inc),
      .redirect  (redirect),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .ir_data   (ir_data),
      .ir_pc     (ir_pc),
      .fetch_err (fetch_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return 16'h1234 + a * 16'h0101;
   endfunction

   // ---------------- stimulus side: PC, memory responder ----------------
   logic [AW-1:0] pc = '0;
   logic [AW-1:0] prev_tgt = '0;
   logic [AW-1:0] last_req_addr = '0;
   logic [AW-1:0] acc_pc = '0;
   bit            prev_redirect = 1'b0;
   bit            prev_inc = 1'b0;
   bit            withhold = 1'b0;
   bit            accepted = 1'b0;
   int            ack_delay = 1;
   int            req_cnt = 0;
   int            inc_count = 0;
   int            inc_bad = 0;
   int            cyc = 0;

   task automatic cycle(input bit rd, input logic [AW-1:0] tgt, input bit rdy);
      @(negedge clk);
      if (prev_redirect)
         pc = prev_tgt;
      else if (prev_inc)
         pc = pc + 16'd1;
      pc_addr   = pc;
      redirect  = rd;
      ir_ready  = rdy;
      mem_ack   = mem_req && !withhold && (req_cnt >= ack_delay);
      mem_rdata = mem_ack ? mem_word(mem_addr) : 16'hDEAD;
      #1;
      if (!rst_n) begin
         prev_inc      = 1'b0;
         prev_redirect = 1'b0;
      end else begin
         prev_inc      = pc_inc;
         prev_redirect = rd;
      end
      prev_tgt = tgt;
      if (mem_req && req_cnt == 0)
         last_req_addr = mem_addr;
      if (mem_req && !mem_ack)
         req_cnt++;
      else
         req_cnt = 0;
      if (pc_inc) inc_count++;
      if (pc_inc && !mem_ack) inc_bad++;
      accepted = ir_valid && rdy && !rd;
      acc_pc   = ir_pc;
      cyc++;
   endtask

   task automatic run_until_valid(input string name);
      int n = 0;
      do begin
         cycle(1'b0, 16'h0, 1'b0);
         n++;
      end while (!ir_valid && n < 30);
      check(name, ir_valid, 1);
   endtask

   // ---------------- transaction-level model + per-cycle compare ----------------
   bit            m_req, m_doomed, m_buf, m_err;
   logic [AW-1:0] m_addr, m_buf_pc;
   logic [DW-1:0] m_buf_data;
   int            m_wait;
   bit            exp_inc;

   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         m_req = 0; m_doomed = 0; m_buf = 0; m_err = 0; m_wait = 0;
         m_addr = '0; m_buf_pc = '0; m_buf_data = '0;
      end else begin
         exp_inc = m_req && mem_ack && !m_doomed && !redirect;
         check("cmp_mem_req", mem_req, m_req);
         if (m_req) check("cmp_mem_addr", mem_addr, m_addr);
         check("cmp_ir_valid", ir_valid, m_buf);
         if (m_buf) begin
            check("cmp_ir_data", ir_data, m_buf_data);
            check("cmp_ir_pc", ir_pc, m_buf_pc);
         end
         check("cmp_pc_inc", pc_inc, exp_inc);
         check("cmp_fetch_err", fetch_err, m_err);
         if (m_buf && ir_ready && !redirect)
            $display("fetch: accepted pc=%04h data=%04h at %0t", m_buf_pc, m_buf_data, $time);
         if (m_req) begin
            if (mem_ack) begin
               m_req = 0;
               if (!m_doomed && !redirect) begin
                  m_buf = 1; m_buf_data = mem_rdata; m_buf_pc = m_addr;
               end
               m_doomed = 0;
`ifdef FETCH_TIMEOUT_EN
            end else if (m_wait == TMO - 1) begin
               m_req = 0; m_doomed = 0; m_err = 1;
`endif
            end else begin
               if (redirect) m_doomed = 1;
               m_wait++;
            end
         end else if (m_buf) begin
            if (redirect) begin
               m_buf = 0;
            end else if (ir_ready) begin
               m_buf = 0; m_req = 1; m_addr = pc_addr; m_wait = 0;
            end
         end else if (!redirect) begin
            m_req = 1; m_addr = pc_addr; m_wait = 0; m_doomed = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int            base;
      int            cnt;
      bit            saw_valid;
      logic [AW-1:0] pcs[$];
      int            accs[$];

      repeat (3) cycle(1'b0, 16'h0, 1'b0);
      check("rst_pc_inc", pc_inc, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_fetch_err", fetch_err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_ir_data", ir_data, 0);
      check("rst_ir_pc", ir_pc, 0);
      rst_n = 1'b1;

      // Single fetch from 0x0000, ack two cycles into the request.
      ack_delay = 2;
      inc_count = 0;
      run_until_valid("t1_valid_wait");
      check("t1_mem_addr", last_req_addr, 16'h0000);
      check("t1_ir_data", ir_data, 16'h1234);
      check("t1_ir_pc", ir_pc, 16'h0000);
      check("t1_pc_inc_count", inc_count, 1);

      // Redirect to 0x0010 from HOLD, then stream four words with ready high.
      cycle(1'b1, 16'h0010, 1'b0);
      ack_delay = 1;
      base = inc_count;
      for (int n = 0; n < 60 && pcs.size() < 4; n++) begin
         cycle(1'b0, 16'h0, 1'b1);
         if (accepted) begin
            pcs.push_back(acc_pc);
            accs.push_back(cyc);
         end
      end
      check("t2_accept_count", pcs.size(), 4);
      for (int i = 0; i < pcs.size(); i++)
         check("t2_ir_pc_seq", pcs[i], 32'h10 + i);
      for (int i = 1; i < accs.size(); i++)
         check("t2_interval", accs[i] - accs[i-1], 3);
      check("t2_pc_inc_count", inc_count - base, 4);

      // Decode stalls five cycles on the next word (0x0014).
      run_until_valid("t3_valid_wait");
      check("t3_ir_pc", ir_pc, 16'h0014);
      check("t3_ir_data", ir_data, mem_word(16'h0014));
      base = inc_count;
      repeat (5) begin
         cycle(1'b0, 16'h0, 1'b0);
         check("t3_mem_req", mem_req, 0);
         check("t3_ir_pc_stable", ir_pc, 16'h0014);
         check("t3_ir_data_stable", ir_data, mem_word(16'h0014));
      end
      check("t3_pc_inc_count", inc_count - base, 0);

      // Redirect to 0x0100 during REQ; the ack arrives three cycles later and is dropped.
      cycle(1'b0, 16'h0, 1'b1);
      ack_delay = 3;
      base = inc_count;
      saw_valid = 1'b0;
      cycle(1'b1, 16'h0100, 1'b0);
      check("t4_req_at_redirect", mem_req, 1);
      cnt = 0;
      while (mem_req && cnt < 20) begin
         cycle(1'b0, 16'h0, 1'b0);
         saw_valid |= ir_valid;
         cnt++;
      end
      check("t4_req_dropped", mem_req, 0);
      cnt = 0;
      while (!mem_req && cnt < 5) begin
         cycle(1'b0, 16'h0, 1'b0);
         saw_valid |= ir_valid;
         cnt++;
      end
      check("t4_new_mem_addr", mem_addr, 16'h0100);
      check("t4_no_ir_valid", saw_valid, 0);
      check("t4_pc_inc_count", inc_count - base, 0);

      // Redirect together with ready in HOLD: one IDLE cycle, then fetch 0x0200.
      ack_delay = 1;
      run_until_valid("t5_valid_wait");
      cycle(1'b1, 16'h0200, 1'b1);
      cycle(1'b0, 16'h0, 1'b0);
      check("t5_ir_valid_low", ir_valid, 0);
      check("t5_idle_no_req", mem_req, 0);
      cycle(1'b0, 16'h0, 1'b0);
      check("t5_req_high", mem_req, 1);
      check("t5_mem_addr", mem_addr, 16'h0200);

      // Withheld ack on the fetch of 0x0201.
      run_until_valid("t6_valid_wait");
      withhold = 1'b1;
      cycle(1'b0, 16'h0, 1'b1);
`ifdef FETCH_TIMEOUT_EN
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         cycle(1'b0, 16'h0, 1'b0);
         if (!mem_req) break;
         cnt++;
      end
      check("t6_req_cycles", cnt, TMO);
      check("t6_fetch_err", fetch_err, 1);
      check("t6_timed_out_addr", last_req_addr, 16'h0201);
      cycle(1'b0, 16'h0, 1'b0);
      check("t6_retry_req", mem_req, 1);
      check("t6_retry_addr", mem_addr, 16'h0201);
      withhold = 1'b0;
      run_until_valid("t6_retry_valid");
      check("t6_err_sticky", fetch_err, 1);
`else
      repeat (10) cycle(1'b0, 16'h0, 1'b0);
      check("t6_req_waits", mem_req, 1);
      check("t6_no_err", fetch_err, 0);
      withhold = 1'b0;
      run_until_valid("t6_late_valid");
`endif
      check("t6_ir_pc", ir_pc, 16'h0201);
      check("t6_ir_data", ir_data, mem_word(16'h0201));

      repeat (3) cycle(1'b0, 16'h0, 1'b1);
      check("pc_inc_outside_ack", inc_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
